// File: rtl/pipe_stage_elastic_pkg.sv
// rtl/pipe_stage_elastic_pkg.sv - shared pipeline types: stage state, per-boundary ctrl/data layouts, bubble constant
package pipe_stage_elastic_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_e;

  // IF/ID boundary
  typedef struct packed {
    logic       ihit;
    logic       halt_seen;
    logic [5:0] rsvd;
  } ifid_ctrl_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } ifid_data_t;

  // ID/EX boundary
  typedef struct packed {
    logic       reg_wr;
    logic       mem_wr;
    logic       dren;
    logic       dwen;
    logic       halt;
    logic       alu_src;
    logic [3:0] alu_op;
    logic [1:0] branch_sel;
    logic [1:0] jump_sel;
    logic [1:0] wsel_src;
  } idex_ctrl_t;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic [31:0] imm;
    logic [31:0] instr;
  } idex_data_t;

  // EX/MEM boundary: 16 ctrl bits and 128 data bits are the stage defaults
  typedef struct packed {
    logic       reg_wr;
    logic       mem_wr;
    logic       dren;
    logic       dwen;
    logic       halt;
    logic [1:0] branch_sel;
    logic [1:0] jump_sel;
    logic [4:0] wsel;
    logic [1:0] rsvd;
  } exmem_ctrl_t;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] alu_res;
    logic [31:0] rdat2;
    logic [31:0] imm;
  } exmem_data_t;

  // MEM/WB boundary
  typedef struct packed {
    logic       reg_wr;
    logic       halt;
    logic [4:0] wsel;
    logic       mem_to_reg;
  } memwb_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] dload;
    logic [31:0] pc_plus4;
  } memwb_data_t;

  // Bubble: every control field inactive
  localparam exmem_ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// rtl/pipe_stage_elastic_if.sv - valid/ready handshake bundle carrying one stage's ctrl and data vectors
interface pipe_stage_elastic_if
  import pipe_stage_elastic_pkg::*;
#(
  parameter int CTRL_W = $bits(exmem_ctrl_t),
  parameter int DATA_W = $bits(exmem_data_t)
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating up-counter with enable, cleared only by reset
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic pipeline register with freeze, flush-to-bubble and optional skid entry
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 16,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic                 CLK,
  input  logic                 nRST,
  pipe_stage_elastic_if.slave  upstream,
  pipe_stage_elastic_if.master downstream,
  input  logic                 freeze,
  input  logic                 flush,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     bp_cycles
);

  localparam logic [1:0] S_EMPTY = 2'(PS_EMPTY);
  localparam logic [1:0] S_ONE   = 2'(PS_ONE);
  localparam logic [1:0] S_TWO   = 2'(PS_TWO);
  localparam bit         SKID_EN = (SKID != 0);
  localparam logic [CTRL_W-1:0] BUBBLE = {CTRL_W{CTRL_NOP[0]}};

  logic [1:0]        state;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic in_ready;
  logic out_valid;
  logic in_fire;
  logic out_fire;
  logic bp_en;

  // Without the skid entry, ready must look through to the downstream ready
  assign in_ready  = !freeze && !flush &&
                     (SKID_EN ? (state != S_TWO) : ((state == S_EMPTY) || downstream.ready));
  assign out_valid = (state != S_EMPTY) && !freeze;
  assign in_fire   = upstream.valid && in_ready;
  assign out_fire  = out_valid && downstream.ready;

  assign upstream.ready   = in_ready;
  assign downstream.valid = out_valid;
  assign downstream.ctrl  = out_valid ? main_ctrl : BUBBLE;
  assign downstream.data  = main_data;
  assign occupancy        = state;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= S_EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      state     <= S_EMPTY;
      main_ctrl <= BUBBLE;
      skid_ctrl <= BUBBLE;
    end else if (!freeze) begin
      case (state)
        S_EMPTY: begin
          if (in_fire) begin
            state     <= S_ONE;
            main_ctrl <= upstream.ctrl;
            main_data <= upstream.data;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl <= upstream.ctrl;
            main_data <= upstream.data;
          end else if (in_fire && SKID_EN) begin
            // main stays the older entry; the newcomer waits behind it
            state     <= S_TWO;
            skid_ctrl <= upstream.ctrl;
            skid_data <= upstream.data;
          end else if (out_fire) begin
            state <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (out_fire) begin
            state     <= S_ONE;
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

  // Counts stalls on the raw state so a flush cycle under backpressure still counts
  assign bp_en = (state != S_EMPTY) && !downstream.ready && !freeze;

  pipe_sat_counter #(
    .W(CNT_W)
  ) u_bp_counter (
    .clk   (CLK),
    .resetn(nRST),
    .en    (bp_en),
    .count (bp_cycles)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - scoreboard bench for pipe_stage_elastic with skid and single-entry instances
module tb_pipe_stage_elastic;
  import pipe_stage_elastic_pkg::*;

  localparam int CW = $bits(exmem_ctrl_t);
  localparam int DW = $bits(exmem_data_t);

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } sb_t;

  logic clk;
  logic nrst;
  logic fz1, fl1, fz0, fl0;
  logic [1:0] occ1, occ0;
  logic [15:0] bp1;
  logic [1:0]  bp0;

  int n_checks = 0;
  int n_fail   = 0;

  sb_t q1[$];
  sb_t q0[$];
  sb_t e1, e0;

  pipe_stage_elastic_if #(.CTRL_W(CW), .DATA_W(DW)) u1 ();
  pipe_stage_elastic_if #(.CTRL_W(CW), .DATA_W(DW)) d1 ();
  pipe_stage_elastic_if #(.CTRL_W(CW), .DATA_W(DW)) u0 ();
  pipe_stage_elastic_if #(.CTRL_W(CW), .DATA_W(DW)) d0 ();

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) dut1 (
    .CLK(clk), .nRST(nrst), .upstream(u1), .downstream(d1),
    .freeze(fz1), .flush(fl1), .occupancy(occ1), .bp_cycles(bp1)
  );

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(2)) dut0 (
    .CLK(clk), .nRST(nrst), .upstream(u0), .downstream(d0),
    .freeze(fz0), .flush(fl0), .occupancy(occ0), .bp_cycles(bp0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CW-1:0] mk_ctrl(input logic [DW-1:0] d);
    logic [CW-1:0] lo;
    lo = d[CW-1:0];
    return lo ^ 16'hC3A5;
  endfunction

  // Scoreboards: push on accepted input, pop and compare on accepted output
  always @(negedge clk) begin
    if (!nrst) begin
      q1.delete();
    end else begin
      if (d1.valid && d1.ready) begin
        n_checks++;
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL sb1_unexpected: got data=%0h, expected no output", d1.data);
        end else begin
          e1 = q1.pop_front();
          if (d1.data !== e1.data || d1.ctrl !== e1.ctrl) begin
            n_fail++;
            $display("FAIL sb1_order: got data=%0h ctrl=%0h, expected data=%0h ctrl=%0h",
                     d1.data, d1.ctrl, e1.data, e1.ctrl);
          end
        end
      end
      if (u1.valid && u1.ready) q1.push_back({u1.ctrl, u1.data});
      if (fl1) q1.delete();
    end
  end

  always @(negedge clk) begin
    if (!nrst) begin
      q0.delete();
    end else begin
      if (d0.valid && d0.ready) begin
        n_checks++;
        if (q0.size() == 0) begin
          n_fail++;
          $display("FAIL sb0_unexpected: got data=%0h, expected no output", d0.data);
        end else begin
          e0 = q0.pop_front();
          if (d0.data !== e0.data || d0.ctrl !== e0.ctrl) begin
            n_fail++;
            $display("FAIL sb0_order: got data=%0h ctrl=%0h, expected data=%0h ctrl=%0h",
                     d0.data, d0.ctrl, e0.data, e0.ctrl);
          end
        end
      end
      if (u0.valid && u0.ready) q0.push_back({u0.ctrl, u0.data});
      if (fl0) q0.delete();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic v, input logic [DW-1:0] d);
    u1.valid = v; u1.data = d; u1.ctrl = mk_ctrl(d);
  endtask

  task automatic send0(input logic v, input logic [DW-1:0] d);
    u0.valid = v; u0.data = d; u0.ctrl = mk_ctrl(d);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    send1(1'b0, '0); send0(1'b0, '0);
    d1.ready = 1'b0; d0.ready = 1'b0;
    fz1 = 1'b0; fl1 = 1'b0; fz0 = 1'b0; fl0 = 1'b0;
    cyc(); cyc();
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    fz1 = 1'b0; fl1 = 1'b0; fz0 = 1'b0; fl0 = 1'b0;
    u1.valid = 1'b1; u1.ctrl = 16'hFFFF; u1.data = '1; d1.ready = 1'b0;
    u0.valid = 1'b1; u0.ctrl = 16'hFFFF; u0.data = '1; d0.ready = 1'b0;
    cyc();
    @(negedge clk);
    n_checks++; if (d1.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", d1.valid); end
    n_checks++; if (d1.ctrl !== '0) begin n_fail++; $display("FAIL reset_ctrl: got %0h expected 0", d1.ctrl); end
    n_checks++; if (d1.data !== '0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", d1.data); end
    n_checks++; if (occ1 !== 2'd0) begin n_fail++; $display("FAIL reset_occ: got %0d expected 0", occ1); end
    n_checks++; if (bp1 !== 16'd0) begin n_fail++; $display("FAIL reset_bp: got %0d expected 0", bp1); end
    n_checks++; if (occ0 !== 2'd0 || d0.ctrl !== '0) begin n_fail++; $display("FAIL reset_dut0: got occ=%0d ctrl=%0h expected 0/0", occ0, d0.ctrl); end
    cyc();
    nrst = 1'b1;
    send1(1'b1, DW'('h77)); send0(1'b0, '0);
    cyc();
    send1(1'b0, '0);
    @(negedge clk);
    n_checks++; if (occ1 !== 2'd1 || bp1 !== 16'd0) begin n_fail++; $display("FAIL first_accept: got occ=%0d bp=%0d expected 1/0", occ1, bp1); end
    #1 nrst = 1'b0;
    #1 nrst = 1'b1;
    cyc();
    @(negedge clk);
    n_checks++; if (occ1 !== 2'd1 || d1.valid !== 1'b1) begin n_fail++; $display("FAIL async_pulse: got occ=%0d valid=%b expected 1/1", occ1, d1.valid); end
    n_checks++; if (bp1 !== 16'd1) begin n_fail++; $display("FAIL async_pulse_bp: got %0d expected 1", bp1); end
    cyc();
    d1.ready = 1'b1;
    cyc();
    d1.ready = 1'b0;
    @(negedge clk);
    n_checks++; if (occ1 !== 2'd0) begin n_fail++; $display("FAIL reset_drain: got occ=%0d expected 0", occ1); end
  endtask

  task automatic test_streaming();
    do_reset();
    d1.ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      send1(1'b1, DW'(i));
      @(negedge clk);
      if (i > 1) begin
        n_checks++;
        if (d1.valid !== 1'b1 || occ1 !== 2'd1 || u1.ready !== 1'b1 || d1.data !== DW'(i - 1)) begin
          n_fail++;
          $display("FAIL stream_%0d: got valid=%b occ=%0d rdy=%b data=%0h expected 1/1/1/%0h",
                   i, d1.valid, occ1, u1.ready, d1.data, i - 1);
        end
      end
      cyc();
    end
    send1(1'b0, '0);
    @(negedge clk);
    n_checks++; if (d1.valid !== 1'b1 || d1.data !== DW'(4)) begin n_fail++; $display("FAIL stream_last: got valid=%b data=%0h expected 1/4", d1.valid, d1.data); end
    cyc();
    @(negedge clk);
    n_checks++; if (occ1 !== 2'd0 || d1.valid !== 1'b0) begin n_fail++; $display("FAIL stream_empty: got occ=%0d valid=%b expected 0/0", occ1, d1.valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    d1.ready = 1'b0;
    send1(1'b1, DW'('hA));
    cyc();
    send1(1'b1, DW'('hB));
    @(negedge clk);
    n_checks++; if (occ1 !== 2'd1 || u1.ready !== 1'b1) begin n_fail++; $display("FAIL bp_one: got occ=%0d rdy=%b expected 1/1", occ1, u1.ready); end
    cyc();
    send1(1'b0, '0);
    @(negedge clk);
    n_checks++; if (occ1 !== 2'd2 || u1.ready !== 1'b0 || bp1 !== 16'd1) begin n_fail++; $display("FAIL bp_two: got occ=%0d rdy=%b bp=%0d expected 2/0/1", occ1, u1.ready, bp1); end
    n_checks++; if (d1.data !== DW'('hA)) begin n_fail++; $display("FAIL bp_head: got %0h expected a", d1.data); end
    cyc();
    d1.ready = 1'b1;
    @(negedge clk);
    n_checks++; if (bp1 !== 16'd2 || occ1 !== 2'd2) begin n_fail++; $display("FAIL bp_count: got bp=%0d occ=%0d expected 2/2", bp1, occ1); end
    cyc();
    @(negedge clk);
    n_checks++; if (occ1 !== 2'd1 || bp1 !== 16'd2 || d1.data !== DW'('hB)) begin n_fail++; $display("FAIL bp_release: got occ=%0d bp=%0d data=%0h expected 1/2/b", occ1, bp1, d1.data); end
    cyc();
    @(negedge clk);
    n_checks++; if (occ1 !== 2'd0) begin n_fail++; $display("FAIL bp_drained: got occ=%0d expected 0", occ1); end
  endtask

  task automatic test_flush();
    do_reset();
    d1.ready = 1'b0;
    send1(1'b1, DW'('h11));
    cyc();
    send1(1'b1, DW'('h22));
    cyc();
    send1(1'b1, DW'('h33));
    fl1 = 1'b1;
    @(negedge clk);
    n_checks++; if (u1.ready !== 1'b0 || occ1 !== 2'd2) begin n_fail++; $display("FAIL flush_pre: got rdy=%b occ=%0d expected 0/2", u1.ready, occ1); end
    cyc();
    fl1 = 1'b0;
    send1(1'b0, '0);
    d1.ready = 1'b1;
    @(negedge clk);
    n_checks++; if (d1.valid !== 1'b0 || d1.ctrl !== '0 || occ1 !== 2'd0) begin n_fail++; $display("FAIL flush_post: got valid=%b ctrl=%0h occ=%0d expected 0/0/0", d1.valid, d1.ctrl, occ1); end
    n_checks++; if (bp1 !== 16'd2) begin n_fail++; $display("FAIL flush_bp_kept: got %0d expected 2", bp1); end
    cyc();
    @(negedge clk);
    n_checks++; if (d1.valid !== 1'b0 || occ1 !== 2'd0) begin n_fail++; $display("FAIL flush_quiet: got valid=%b occ=%0d expected 0/0", d1.valid, occ1); end
  endtask

  task automatic test_freeze();
    do_reset();
    d1.ready = 1'b1;
    send1(1'b1, DW'('h55));
    cyc();
    send1(1'b1, DW'('h66));
    fz1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) d1.ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (d1.valid !== 1'b0 || u1.ready !== 1'b0 || occ1 !== 2'd1 || bp1 !== 16'd0) begin
        n_fail++;
        $display("FAIL freeze_%0d: got valid=%b rdy=%b occ=%0d bp=%0d expected 0/0/1/0",
                 k, d1.valid, u1.ready, occ1, bp1);
      end
      cyc();
    end
    fz1 = 1'b0;
    send1(1'b0, '0);
    d1.ready = 1'b1;
    @(negedge clk);
    n_checks++; if (d1.valid !== 1'b1 || d1.data !== DW'('h55)) begin n_fail++; $display("FAIL freeze_release: got valid=%b data=%0h expected 1/55", d1.valid, d1.data); end
    cyc();
    @(negedge clk);
    n_checks++; if (d1.valid !== 1'b0 || occ1 !== 2'd0) begin n_fail++; $display("FAIL freeze_once: got valid=%b occ=%0d expected 0/0", d1.valid, occ1); end
  endtask

  task automatic test_skid0();
    do_reset();
    d0.ready = 1'b0;
    send0(1'b1, DW'('h10));
    @(negedge clk);
    n_checks++; if (u0.ready !== 1'b1) begin n_fail++; $display("FAIL s0_empty_rdy: got %b expected 1", u0.ready); end
    cyc();
    send0(1'b1, DW'('h20));
    @(negedge clk);
    n_checks++; if (u0.ready !== 1'b0 || occ0 !== 2'd1) begin n_fail++; $display("FAIL s0_blocked: got rdy=%b occ=%0d expected 0/1", u0.ready, occ0); end
    cyc();
    @(negedge clk);
    n_checks++; if (occ0 !== 2'd1 || bp0 !== 2'd1) begin n_fail++; $display("FAIL s0_hold: got occ=%0d bp=%0d expected 1/1", occ0, bp0); end
    cyc();
    d0.ready = 1'b1;
    @(negedge clk);
    n_checks++; if (u0.ready !== 1'b1) begin n_fail++; $display("FAIL s0_passthru_rdy: got %b expected 1", u0.ready); end
    cyc();
    send0(1'b0, '0);
    d0.ready = 1'b0;
    @(negedge clk);
    n_checks++; if (occ0 !== 2'd1 || d0.data !== DW'('h20) || bp0 !== 2'd2) begin n_fail++; $display("FAIL s0_replace: got occ=%0d data=%0h bp=%0d expected 1/20/2", occ0, d0.data, bp0); end
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      n_checks++; if (bp0 !== 2'd3) begin n_fail++; $display("FAIL s0_sat_%0d: got %0d expected 3", k, bp0); end
    end
    cyc();
    d0.ready = 1'b1;
    cyc();
    d0.ready = 1'b0;
    @(negedge clk);
    n_checks++; if (occ0 !== 2'd0) begin n_fail++; $display("FAIL s0_drained: got occ=%0d expected 0", occ0); end
  endtask

  task automatic test_scoreboard_empty();
    n_checks++; if (q1.size() != 0) begin n_fail++; $display("FAIL sb1_leftover: got %0d entries expected 0", q1.size()); end
    n_checks++; if (q0.size() != 0) begin n_fail++; $display("FAIL sb0_leftover: got %0d entries expected 0", q0.size()); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0;
    fz1 = 1'b0; fl1 = 1'b0; fz0 = 1'b0; fl0 = 1'b0;
    send1(1'b0, '0); send0(1'b0, '0);
    d1.ready = 1'b0; d0.ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_freeze();
    test_skid0();
    test_scoreboard_empty();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised pipeline-stage register for the pipelined datapath. It generalises the fixed field-by-field inter-stage latch into one width-generic stage with a valid/ready handshake, a global freeze, and a flush that inserts a bubble. An optional 2-entry skid buffer breaks the combinational ready path. It instantiates between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB) by packing that stage's control and data fields into ctrl/data vectors.

Parameters:
DATA_W, 128, width of payload vector (PC+4, rdat1/2, ALU result, instr, imm, ...); no reset-to-zero requirement beyond reset
CTRL_W, 16, width of control vector (RegWr, MemWr, dREN, dWEN, halt, branch/jump selects); forced to zero when stage is not valid
SKID, 1, 1 = two entries (main + skid), registered in_ready; 0 = single entry, pass-through ready
CNT_W, 16, width of saturating backpressure counter

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  synchronous active-low reset
in_valid  in  1  upstream has an instruction
in_ready  out  1  stage can accept
in_ctrl  in  CTRL_W  upstream control fields
in_data  in  DATA_W  upstream payload fields
freeze  in  1  global hold (e.g. waiting on dhit/ihit); no transfers on either side
flush  in  1  squash all held and incoming entries (branch/jump resolve)
out_valid  out  1  stage holds a valid instruction
out_ready  in  1  downstream can accept
out_ctrl  out  CTRL_W  main-entry control, zero when out_valid=0
out_data  out  DATA_W  main-entry payload (don't-care when out_valid=0)
occupancy  out  2  entries held: 0, 1, 2
bp_cycles  out  CNT_W  saturating count of cycles with out_valid=1, out_ready=0, freeze=0

Behaviour:
- Reset is synchronous: when nRST=0 at a rising CLK edge, state becomes EMPTY, main/skid ctrl and data become 0, and bp_cycles becomes 0. Therefore out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
- Priority at each edge: reset > flush > freeze > normal operation.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- in_ready = !freeze & !flush & (SKID ? state!=TWO : (state==EMPTY | out_ready)).
- out_valid = (state!=EMPTY) & !freeze. out_ctrl = out_valid ? main_ctrl : 0.
- States are EMPTY, ONE, TWO. TWO is reachable only when SKID=1.
  - EMPTY: in_fire -> ONE, main<=in.
  - ONE with in_fire & out_fire -> ONE, main<=in.
  - ONE with in_fire & !out_fire -> TWO, skid<=in (SKID=1 only).
  - ONE with !in_fire & out_fire -> EMPTY.
  - ONE, otherwise -> hold.
  - TWO: out_fire -> ONE, main<=skid. Otherwise hold. in_ready=0 in TWO.
- Ordering: main is always the older entry. Entries never reorder or duplicate.
- flush=1: next state is EMPTY and main/skid ctrl are cleared to 0. Data registers are not required to clear. Any in_valid in the same cycle is dropped, since in_ready=0.
- freeze=1 without flush: every register holds, including bp_cycles. in_ready=0 and out_valid=0, so no transfer occurs.
- occupancy encodes the state: EMPTY=0, ONE=1, TWO=2.
- bp_cycles increments when the raw state!=EMPTY, out_ready=0 and freeze=0. It saturates at 2^CNT_W-1 and clears only on reset, not on flush.
- Latency is 1 cycle from in_fire to out_valid when the stage was EMPTY. Throughput is 1/cycle when out_ready is held high.
- Reset mid-transfer discards all entries. The first accept after reset is the first cycle with nRST=1.

Decomposition:
- A shared pipeline package holds:
  - the state enum (EMPTY, ONE, TWO);
  - packed struct typedefs per stage boundary (e.g. exmem_ctrl_t, exmem_data_t), so callers pass $bits(...) as CTRL_W and DATA_W;
  - the bubble constant CTRL_NOP='0.
- One natural sub-module: pipe_sat_counter (CNT_W, increment enable, saturate) for bp_cycles.

Test Plan:
- Reset: hold nRST=0 with in_valid=1 and in_ctrl=16'hFFFF -> after the edge, out_valid=0, out_ctrl=0, occupancy=0, bp_cycles=0. An async nRST pulse between edges must have no effect.
- Streaming, SKID=1: present in_data=1,2,3,4 on consecutive cycles with out_ready=1 -> out_data 1,2,3,4 one cycle later, no gaps, occupancy stays 1.
- Backpressure: out_ready=0 while sending 0xA then 0xB -> occupancy=2, in_ready=0, bp_cycles increments each cycle. Raising out_ready -> 0xA then 0xB out in order.
- Flush: occupancy=2 and in_valid=1 with flush=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0. The incoming word never appears.
- Freeze: hold freeze=1 for 3 cycles at occupancy=1 with out_ready=1 -> out_valid=0, state and bp_cycles unchanged. After release the same word emerges once.
- SKID=0: out_ready=0 at occupancy=1 -> in_ready=0. out_ready=1 -> in_ready=1 the same cycle and the entry is replaced. bp_cycles with CNT_W=2 saturates at 3.
